// File: rtl/chip_select_decoder_if.sv
// Bus bundle for chip_select_decoder.
//   master : drives select address, enables, address strobe and wait table;
//            observes chip selects, data-transfer acknowledge and busy.
//   slave  : the decoder side of the same signals.
// Signal widths follow SEL_W (address) and WAIT_W (per-output wait count);
// N = 2**SEL_W chip selects.
interface chip_select_decoder_if #(
   parameter int unsigned SEL_W  = 3,
   parameter int unsigned WAIT_W = 4
) ();
   localparam int unsigned N = 2**SEL_W;

   logic [SEL_W-1:0]    a;
   logic                e1_n;
   logic                e2_n;
   logic                e3;
   logic                as_n;
   logic [N*WAIT_W-1:0] wait_cfg;
   logic [N-1:0]        y_n;
   logic                dtack_n;
   logic                busy;

   modport master (
      output a, e1_n, e2_n, e3, as_n, wait_cfg,
      input  y_n, dtack_n, busy
   );

   modport slave (
      input  a, e1_n, e2_n, e3, as_n, wait_cfg,
      output y_n, dtack_n, busy
   );
endinterface

// File: rtl/chip_select_decoder.sv
// Registered chip-select decoder with per-output wait states.
//   clk   : single clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset, highest priority
//   bus   : slave side of chip_select_decoder_if
//           a/e1_n/e2_n/e3/as_n/wait_cfg in; y_n/dtack_n/busy out
// A bus cycle starts when the decoder is idle, enabled and as_n is low: the
// addressed select goes low on that edge, dtack_n follows 1+W edges later
// (W = that output's wait count captured at the start edge). Losing the
// enable or the strobe ends the cycle at the next edge.
module chip_select_decoder #(
   parameter int unsigned SEL_W  = 3,
   parameter int unsigned WAIT_W = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   chip_select_decoder_if.slave bus
);
   localparam int unsigned N = 2**SEL_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [WAIT_W-1:0]  cnt_q, cnt_d;
   logic [N-1:0]       y_n_q, y_n_d;
   logic               dtack_n_q, dtack_n_d;

   logic               en;
   logic               abort;
   logic [WAIT_W-1:0]  wait_sel;

   assign en    = !bus.e1_n && !bus.e2_n && bus.e3;
   assign abort = !en || bus.as_n;

   // Wait count of the currently addressed output; only used at the start edge.
   always_comb begin
      wait_sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i == 32'(bus.a)) wait_sel = bus.wait_cfg[i*WAIT_W +: WAIT_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      y_n_d     = '1;
      dtack_n_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (!abort) begin
               sel_d   = bus.a;
               cnt_d   = wait_sel;
               y_n_d   = ~(N'(1) << bus.a);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Abort wins over the terminal-count transition.
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               y_n_d = ~(N'(1) << sel_q);
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - WAIT_W'(1);
               end else begin
                  dtack_n_d = 1'b0;
                  state_d   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               y_n_d     = ~(N'(1) << sel_q);
               dtack_n_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         y_n_q     <= '1;
         dtack_n_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         y_n_q     <= y_n_d;
         dtack_n_q <= dtack_n_d;
      end
   end

   assign bus.y_n     = y_n_q;
   assign bus.dtack_n = dtack_n_q;
   assign bus.busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_chip_select_decoder.sv
// Self-checking bench for chip_select_decoder: directed vector table,
// hand-written multi-cycle sequences, a SEL_W=4 instance and randomized
// stimulus against an edge-counting reference model.
module tb_chip_select_decoder;
   logic clk;
   logic rst_n;

   chip_select_decoder_if #(.SEL_W(3), .WAIT_W(4)) bus3 ();
   chip_select_decoder_if #(.SEL_W(4), .WAIT_W(4)) bus4 ();

   chip_select_decoder #(.SEL_W(3), .WAIT_W(4)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   chip_select_decoder #(.SEL_W(4), .WAIT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive3(input logic [2:0] a, input logic e1n, input logic e2n,
                         input logic e3, input logic asn, input logic [31:0] cfg);
      bus3.a        = a;
      bus3.e1_n     = e1n;
      bus3.e2_n     = e2n;
      bus3.e3       = e3;
      bus3.as_n     = asn;
      bus3.wait_cfg = cfg;
   endtask

   task automatic chk3(input string nm, input logic [7:0] y, input logic dt, input logic bz);
      chk({nm, ".y_n"},     64'(bus3.y_n),     64'(y));
      chk({nm, ".dtack_n"}, 64'(bus3.dtack_n), 64'(dt));
      chk({nm, ".busy"},    64'(bus3.busy),    64'(bz));
   endtask

   // Directed vector table: inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic        rst_n;
      logic [2:0]  a;
      logic        e1_n, e2_n, e3, as_n;
      logic [31:0] cfg;
      logic [7:0]  y;
      logic        dt;
      logic        bz;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic r, input logic [2:0] a, input logic e1n,
                               input logic e2n, input logic e3, input logic asn,
                               input logic [31:0] cfg, input logic [7:0] y,
                               input logic dt, input logic bz);
      vec_t v;
      v.rst_n = r; v.a = a; v.e1_n = e1n; v.e2_n = e2n; v.e3 = e3; v.as_n = asn;
      v.cfg = cfg; v.y = y; v.dt = dt; v.bz = bz;
      return v;
   endfunction

   // Reference model: a cycle is "active" from its start edge until the edge
   // that ends it; dtack is due from start_edge + 1 + W onwards.
   int unsigned edge_no;
   bit          m_act;
   int unsigned m_sel;
   int unsigned m_ack_edge;

   task automatic model_edge();
      bit en;
      edge_no++;
      en = !bus3.e1_n && !bus3.e2_n && bus3.e3;
      if (!rst_n) begin
         m_act = 0;
      end else if (m_act) begin
         if (!en || bus3.as_n) m_act = 0;
      end else if (en && !bus3.as_n) begin
         m_act      = 1;
         m_sel      = bus3.a;
         m_ack_edge = edge_no + 1 + ((bus3.wait_cfg >> (4 * m_sel)) & 32'hF);
      end
   endtask

   initial begin
      logic [31:0] cfgA;
      logic [31:0] cfgB;
      logic [7:0]  ey;
      logic        edt;

      cfgA = 32'h7654_3021;   // slice 2 = 0
      cfgB = 32'hFF3F_FFFF;   // slice 5 = 3

      rst_n = 1'b0;
      drive3(3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      bus4.a = 4'h0; bus4.e1_n = 1'b0; bus4.e2_n = 1'b0; bus4.e3 = 1'b1;
      bus4.as_n = 1'b1; bus4.wait_cfg = '0;

      tbl[0]  = mk(0, 3'd0, 0, 0, 1, 1, cfgA, 8'hFF, 1, 0);
      tbl[1]  = mk(1, 3'd0, 0, 0, 1, 1, cfgA, 8'hFF, 1, 0);
      tbl[2]  = mk(1, 3'd2, 0, 0, 1, 0, cfgA, 8'hFB, 1, 1);
      tbl[3]  = mk(1, 3'd2, 0, 0, 1, 0, cfgA, 8'hFB, 0, 1);
      tbl[4]  = mk(1, 3'd2, 0, 0, 1, 0, cfgA, 8'hFB, 0, 1);
      tbl[5]  = mk(1, 3'd2, 0, 0, 1, 1, cfgA, 8'hFF, 1, 0);
      tbl[6]  = mk(1, 3'd2, 0, 0, 1, 1, cfgA, 8'hFF, 1, 0);
      tbl[7]  = mk(1, 3'd2, 0, 0, 0, 0, cfgA, 8'hFF, 1, 0);
      tbl[8]  = mk(1, 3'd2, 0, 1, 1, 0, cfgA, 8'hFF, 1, 0);
      tbl[9]  = mk(1, 3'd2, 1, 0, 1, 0, cfgA, 8'hFF, 1, 0);
      tbl[10] = mk(1, 3'd5, 0, 0, 1, 0, cfgB, 8'hDF, 1, 1);
      tbl[11] = mk(1, 3'd5, 0, 0, 1, 0, cfgB, 8'hDF, 1, 1);
      tbl[12] = mk(1, 3'd5, 0, 0, 1, 0, cfgB, 8'hDF, 1, 1);
      tbl[13] = mk(1, 3'd5, 0, 0, 1, 0, cfgB, 8'hDF, 1, 1);
      tbl[14] = mk(1, 3'd5, 0, 0, 1, 0, cfgB, 8'hDF, 0, 1);
      tbl[15] = mk(1, 3'd5, 0, 0, 1, 1, cfgB, 8'hFF, 1, 0);

      for (int i = 0; i < 16; i++) begin
         rst_n = tbl[i].rst_n;
         drive3(tbl[i].a, tbl[i].e1_n, tbl[i].e2_n, tbl[i].e3, tbl[i].as_n, tbl[i].cfg);
         step();
         chk3($sformatf("vec%0d", i), tbl[i].y, tbl[i].dt, tbl[i].bz);
         if (i == 0) chk("rst4.y_n", 64'(bus4.y_n), 64'hFFFF);
      end

      // Mid-cycle address/wait changes are ignored: a=6 with W=5.
      drive3(3'd6, 0, 0, 1, 0, 32'h0500_0000);
      step();
      chk3("chg.k", 8'hBF, 1, 1);
      drive3(3'd3, 0, 0, 1, 0, 32'hFFFF_FFFF);
      for (int j = 1; j <= 6; j++) begin
         step();
         chk3($sformatf("chg.k+%0d", j), 8'hBF, (j == 6) ? 1'b0 : 1'b1, 1);
      end
      drive3(3'd3, 0, 0, 1, 1, 32'hFFFF_FFFF);
      step();
      chk3("chg.end", 8'hFF, 1, 0);

      // Abort during wait states: W=7, e3 dropped before edge k+2.
      drive3(3'd0, 0, 0, 1, 0, 32'h0000_0007);
      step();
      chk3("abt.k", 8'hFE, 1, 1);
      step();
      chk3("abt.k+1", 8'hFE, 1, 1);
      drive3(3'd0, 0, 0, 0, 0, 32'h0000_0007);
      step();
      chk3("abt.k+2", 8'hFF, 1, 0);
      step();
      chk3("abt.k+3", 8'hFF, 1, 0);
      drive3(3'd0, 0, 0, 1, 1, 32'h0000_0007);
      step();

      // Reset while acknowledging.
      drive3(3'd1, 0, 0, 1, 0, 32'h0);
      step();
      chk3("rack.k", 8'hFD, 1, 1);
      step();
      chk3("rack.k+1", 8'hFD, 0, 1);
      rst_n = 1'b0;
      step();
      chk3("rack.rst", 8'hFF, 1, 0);
      drive3(3'd1, 0, 0, 1, 1, 32'h0);
      rst_n = 1'b1;
      step();
      chk3("rack.idle", 8'hFF, 1, 0);

      // SEL_W=4 instance, top output.
      bus4.a = 4'hF; bus4.as_n = 1'b0;
      step();
      chk("w4.k.y_n",      64'(bus4.y_n),     64'h7FFF);
      chk("w4.k.busy",     64'(bus4.busy),    64'd1);
      step();
      chk("w4.k+1.y_n",    64'(bus4.y_n),     64'h7FFF);
      chk("w4.k+1.dtack",  64'(bus4.dtack_n), 64'd0);
      bus4.as_n = 1'b1;
      step();
      chk("w4.end.y_n",    64'(bus4.y_n),     64'hFFFF);
      chk("w4.end.dtack",  64'(bus4.dtack_n), 64'd1);

      // Randomized run against the reference model.
      edge_no = 0;
      rst_n = 1'b0;
      model_edge();
      step();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         drive3(3'($urandom_range(0, 7)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 15) != 0),
                ($urandom_range(0, 7) == 0),
                $urandom & 32'h7777_7777);
         model_edge();
         step();
         ey  = m_act ? ~(8'd1 << m_sel) : 8'hFF;
         edt = (m_act && edge_no >= m_ack_edge) ? 1'b0 : 1'b1;
         chk3($sformatf("rnd%0d", c), ey, edt, m_act);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
